// File: rtl/load_store_unit.sv
// Load/store unit for the MEM stage: drives a req/gnt/rvalid data memory port,
// formats load data and store lanes, and stalls the pipeline while an access is pending.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_i,
   input  logic [31:0] alu_result_i,
   input  logic [31:0] rs2_data_i,
   input  logic [2:0]  funct3_i,
   input  logic        mem_read_c_i,
   input  logic        mem_write_c_i,
   input  logic [4:0]  rd_i,
   input  logic [31:0] pc_next_i,
   input  logic        reg_write_c_i,
   input  logic [1:0]  wb_data_sel_c_i,
   input  logic        freeze_i,
   output logic [4:0]  rd_o,
   output logic [31:0] alu_result_o,
   output logic [31:0] pc_next_o,
   output logic [1:0]  wb_data_sel_c_o,
   output logic        reg_write_c_o,
   output logic [31:0] mem_read_data_o,
   output logic        stall_c_o,
   output logic        misaligned_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [31:0] dmem_addr_o,
   output logic [31:0] dmem_wdata_o,
   output logic [3:0]  dmem_be_o,
   input  logic        dmem_gnt_i,
   input  logic        dmem_rvalid_i,
   input  logic [31:0] dmem_rdata_i
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] WAIT = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]  state;
   logic [1:0]  state_next;
   logic [31:0] hold_data;
   logic [31:0] load_fmt;
   logic        is_byte;
   logic        is_half;
   logic        is_word;
   logic        mem_op;
   logic        access;

   // Size comes from funct3[1:0]; the reserved encodings fall through to word.
   assign is_byte = (funct3_i[1:0] == 2'b00);
   assign is_half = (funct3_i[1:0] == 2'b01);
   assign is_word = ~is_byte & ~is_half;
   assign mem_op  = valid_i & (mem_read_c_i | mem_write_c_i);

   assign misaligned_o = mem_op & ((is_word & (alu_result_i[1:0] != 2'b00)) |
                                   (is_half & alu_result_i[0]));
   assign access       = mem_op & ~misaligned_o;

   assign rd_o            = rd_i;
   assign alu_result_o    = alu_result_i;
   assign pc_next_o       = pc_next_i;
   assign wb_data_sel_c_o = wb_data_sel_c_i;
   assign reg_write_c_o   = reg_write_c_i & valid_i & ~misaligned_o;

   assign dmem_addr_o = {alu_result_i[31:2], 2'b00};
   assign dmem_we_o   = dmem_req_o & mem_write_c_i;

   always_comb begin
      dmem_be_o    = 4'b1111;
      dmem_wdata_o = rs2_data_i;
      if (mem_write_c_i) begin
         if (is_byte) begin
            dmem_be_o    = 4'b0001 << alu_result_i[1:0];
            dmem_wdata_o = {4{rs2_data_i[7:0]}};
         end else if (is_half) begin
            dmem_be_o    = alu_result_i[1] ? 4'b1100 : 4'b0011;
            dmem_wdata_o = {2{rs2_data_i[15:0]}};
         end
      end
   end

   // Lane select plus sign/zero extension of the raw memory word.
   always_comb begin
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      lane_b   = 8'h00;
      lane_h   = 16'h0000;
      load_fmt = dmem_rdata_i;
      case (alu_result_i[1:0])
         2'b00:   lane_b = dmem_rdata_i[7:0];
         2'b01:   lane_b = dmem_rdata_i[15:8];
         2'b10:   lane_b = dmem_rdata_i[23:16];
         default: lane_b = dmem_rdata_i[31:24];
      endcase
      lane_h = alu_result_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
      case (funct3_i)
         3'b000:  load_fmt = {{24{lane_b[7]}}, lane_b};
         3'b001:  load_fmt = {{16{lane_h[15]}}, lane_h};
         3'b100:  load_fmt = {24'h000000, lane_b};
         3'b101:  load_fmt = {16'h0000, lane_h};
         default: load_fmt = dmem_rdata_i;
      endcase
   end

   // Request/stall generation; a store completes on grant, a load on rvalid.
   always_comb begin
      state_next = state;
      dmem_req_o = 1'b0;
      stall_c_o  = 1'b0;
      case (state)
         IDLE, REQ: begin
            if (access) begin
               dmem_req_o = 1'b1;
               if (dmem_gnt_i) begin
                  if (mem_write_c_i) begin
                     state_next = freeze_i ? DONE : IDLE;
                  end else begin
                     state_next = WAIT;
                     stall_c_o  = 1'b1;
                  end
               end else begin
                  state_next = REQ;
                  stall_c_o  = 1'b1;
               end
            end else begin
               state_next = IDLE;
            end
         end
         WAIT: begin
            if (dmem_rvalid_i) begin
               state_next = freeze_i ? DONE : IDLE;
            end else begin
               stall_c_o = 1'b1;
            end
         end
         default: begin
            if (!freeze_i) begin
               state_next = IDLE;
            end
         end
      endcase
   end

   always_comb begin
      mem_read_data_o = 32'h0;
      if ((state == WAIT) && dmem_rvalid_i) begin
         mem_read_data_o = load_fmt;
      end else if (state == DONE) begin
         mem_read_data_o = hold_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hold_data <= 32'h0;
      end else begin
         state <= state_next;
         if ((state == WAIT) && dmem_rvalid_i) begin
            hold_data <= load_fmt;
         end
      end
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock, sole clock.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 valid_i  in  1  EX/MEM slot holds a live instruction.
REQ-005 alu_result_i  in  32  effective address / ALU result.
REQ-006 rs2_data_i  in  32  store data.
REQ-007 funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 mem_read_c_i, mem_write_c_i  in  1 each  load / store; never both 1.
REQ-009 rd_i (5), pc_next_i (32), reg_write_c_i (1), wb_data_sel_c_i (2)  in  writeback controls.
REQ-010 freeze_i  in  1  external pipeline stall holding the EX/MEM slot.
REQ-011 rd_o, alu_result_o, pc_next_o, wb_data_sel_c_o  out  5/32/32/2  pass-through of inputs to MEM2WB.
REQ-012 reg_write_c_o  out  1  reg_write_c_i & valid_i & ~misaligned_o.
REQ-013 mem_read_data_o  out  32  aligned, extended load data.
REQ-014 stall_c_o  out  1  memory access in progress; freezes PC through EX/MEM, bubbles MEM2WB.
REQ-015 misaligned_o  out  1  current access misaligned.
REQ-016 dmem_req_o, dmem_we_o  out  1 each  request / write strobe.
REQ-017 dmem_addr_o  out  32  {alu_result_i[31:2],2'b00}.
REQ-018 dmem_wdata_o  out  32; dmem_be_o  out  4  write data and byte enables.
REQ-019 dmem_gnt_i, dmem_rvalid_i  in  1 each; dmem_rdata_i  in  32  memory response.

Function
REQ-020 Access = valid_i & (mem_read_c_i | mem_write_c_i) & ~misaligned_o.
REQ-021 Misaligned: W with addr[1:0]!=0, H/HU with addr[0]=1; no request issued, no stall, reg_write_c_o=0.
REQ-022 FSM states IDLE, REQ, WAIT, DONE.
REQ-023 IDLE: access -> dmem_req_o=1 combinationally same cycle; gnt=1 -> store: DONE if freeze_i else IDLE; load: WAIT; gnt=0 -> REQ.
REQ-024 REQ: dmem_req_o=1, addr/we/be/wdata stable until gnt; on gnt same exits as REQ-023.
REQ-025 WAIT: dmem_req_o=0; rvalid=1 -> capture formatted data into hold register; next state DONE if freeze_i else IDLE.
REQ-026 dmem_rvalid_i SHALL be ignored in IDLE, REQ, DONE; it arrives at earliest one cycle after gnt.
REQ-027 DONE: no request reissued; mem_read_data_o driven from hold register; exit to IDLE when freeze_i=0.
REQ-028 stall_c_o=1 while access pending: IDLE/REQ without gnt on a store, or any load cycle before rvalid; 0 in completion cycle and in DONE.
REQ-029 Store latency = grant cycle; load latency = rvalid cycle; zero-wait memory gives 1 cycle store, 2 cycle load.
REQ-030 be: SB 4'b0001<<addr[1:0]; SH 4'b0011<<{addr[1],1'b0}; SW 4'b1111; loads 4'b1111, we=0.
REQ-031 wdata: SB {4{rs2[7:0]}}, SH {2{rs2[15:0]}}, SW rs2.
REQ-032 Load data: select byte addr[1:0] / halfword addr[1]; B,H sign-extend, BU,HU zero-extend, W unchanged.
REQ-033 mem_read_data_o = formatted rdata in rvalid cycle, hold register in DONE, else 32'h0.
REQ-034 Undefined funct3 SHALL be treated as W.

Reset
REQ-035 rst: state IDLE, hold register 0, dmem_req_o=0, stall_c_o=0 in the following cycle.
REQ-036 rst mid-access drops request; late rvalid after reset ignored.
REQ-037 rst overrides freeze_i and all inputs.

Verification
REQ-038 LW addr 0x100, gnt same cycle, rvalid next, rdata 0xDEADBEEF -> stall 1 cycle, mem_read_data_o 0xDEADBEEF.
REQ-039 LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU -> 0x00000080.
REQ-040 SH addr 0x102, rs2 0x0000ABCD, gnt delayed 3 cycles -> stall 3 cycles, be 1100, wdata 0xABCDABCD held stable.
REQ-041 LW addr 0x101 -> misaligned_o=1, dmem_req_o=0, reg_write_c_o=0, stall 0.
REQ-042 LH completes while freeze_i=1 for 2 cycles -> one request only, data held in DONE, IDLE after release.
REQ-043 rst asserted in WAIT, rvalid arrives next cycle -> IDLE, data ignored, stall 0.
